ru_dump: RTL

- Read-side initiator for the register unit: drives the two asynchronous read ports (rs1/rs2) to sweep the whole register file.
- Captures two registers per fetch and streams them out one word at a time over a valid/ready channel, each word tagged with its register index.
- Used for debug/trace dumps and end-of-program register checks.
- Requests a core hold while active, so no writes race the sweep.

---
 rtl/rv_pkg.sv | 28 ++
 rtl/ru_dump.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the register-unit side of the core.
//   XLEN     : register word width
//   NREGS    : number of architectural registers (even, power of 2)
//   AW       : register index width, log2(NREGS)
//   reg_idx_t: register index type
//   word_t   : register word type
//   dump_state_t: state encoding of the register dump sequencer
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SEND_A = 3'd2,
    SEND_B = 3'd3,
    FIN    = 3'd4
  } dump_state_t;

endpackage

// File: rtl/ru_dump.sv
// ---------------------------------------------------------------------------
// ru_dump
// Sweeps the whole register file through the two asynchronous RU read ports
// and streams every register out, one word per handshake, tagged with its
// index. Two registers (an even/odd pair) are captured per fetch.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle dump request, honoured only in IDLE
//   abort             : cancel an active dump (no done pulse)
//   hold_req, busy    : high whenever the sequencer is not IDLE
//   done              : one-cycle pulse after the last word is accepted
//   rs1, rs2          : RU read addresses, even/odd index of current pair
//   RU_rs1, RU_rs2    : combinational RU read data
//   dump_valid/ready  : output word channel
//   dump_idx/data     : index and value of the presented word
//   dbg_state         : current sequencer state
//
// Output channel: a word is transferred on a rising edge where dump_valid and
// dump_ready are both high. Once dump_valid is high, dump_idx and dump_data
// hold steady until that transfer; dump_valid only falls after a transfer,
// on abort, or on reset. dump_ready while dump_valid is low is ignored.
// ---------------------------------------------------------------------------
module ru_dump
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        hold_req,
  output logic        busy,
  output logic        done,
  output reg_idx_t    rs1,
  output reg_idx_t    rs2,
  input  word_t       RU_rs1,
  input  word_t       RU_rs2,
  output logic        dump_valid,
  input  logic        dump_ready,
  output reg_idx_t    dump_idx,
  output word_t       dump_data,
  output dump_state_t dbg_state
);

  localparam int PW = AW - 1;
  localparam logic [PW-1:0] LAST_PAIR = PW'(NREGS / 2 - 1);

  dump_state_t   r_state;
  logic [PW-1:0] r_pair;
  word_t         r_buf_a;
  word_t         r_buf_b;
  logic          r_busy;
  logic          r_done;
  logic          r_valid;
  logic          w_hs;
  logic          w_odd;

  assign w_hs  = r_valid & dump_ready;
  // The odd word of the pair is on the channel only in SEND_B.
  assign w_odd = (r_state == SEND_B);

  // Read addresses come straight from the pair counter register, so they are
  // stable for the whole FETCH cycle and change on the edge the pair advances.
  assign rs1 = {r_pair, 1'b0};
  assign rs2 = {r_pair, 1'b1};

  assign hold_req   = r_busy;
  assign busy       = r_busy;
  assign done       = r_done;
  assign dump_valid = r_valid;
  assign dump_idx   = {r_pair, w_odd};
  assign dump_data  = w_odd ? r_buf_b : r_buf_a;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pair  <= '0;
      r_buf_a <= '0;
      r_buf_b <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Abort overrides everything, including a handshake in the same cycle.
      // In IDLE it also masks a simultaneous start.
      if (abort) begin
        r_state <= IDLE;
        r_pair  <= '0;
        r_busy  <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state <= FETCH;
              r_busy  <= 1'b1;
            end
          end
          FETCH: begin
            r_buf_a <= RU_rs1;
            r_buf_b <= RU_rs2;
            r_valid <= 1'b1;
            r_state <= SEND_A;
          end
          SEND_A: begin
            if (w_hs) begin
              r_state <= SEND_B;
            end
          end
          SEND_B: begin
            if (w_hs) begin
              r_valid <= 1'b0;
              if (r_pair == LAST_PAIR) begin
                r_state <= FIN;
                r_done  <= 1'b1;
              end else begin
                r_pair  <= r_pair + 1'b1;
                r_state <= FETCH;
              end
            end
          end
          FIN: begin
            r_state <= IDLE;
            r_pair  <= '0;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_pair  <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
